rob: RTL and testbench

ROB -- requirements
Module: rob

---
 rtl/rob.sv | 213 +++++++++++++++++++++
 tb/tb_rob.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rob.sv
// Reorder buffer: in-order commit of out-of-order results, with
// operand queries, store release and branch-mispredict rollback.
`ifndef ROB_IDX_TP
`define ROB_IDX_TP logic [ROB_BIT-1:0]
`endif
`ifndef REG_IDX_TP
`define REG_IDX_TP logic [4:0]
`endif
`ifndef WORD_TP
`define WORD_TP logic [31:0]
`endif
`ifndef ADDR_TP
`define ADDR_TP logic [31:0]
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'h0
`endif
`ifndef ZERO_ROB_IDX
`define ZERO_ROB_IDX '0
`endif

module rob #(
  parameter int ROB_BIT  = 4,
  parameter int ROB_SIZE = (1 << ROB_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       id_alloc,
  input  `REG_IDX_TP id_rd,
  input  logic       id_is_br,
  input  logic       id_is_st,
  input  logic       id_pred_taken,
  output `ROB_IDX_TP id_idx,
  output logic       id_full,
  input  `ROB_IDX_TP id_qry1,
  input  `ROB_IDX_TP id_qry2,
  output logic       id_qry1_rdy,
  output logic       id_qry2_rdy,
  output `WORD_TP    id_qry1_val,
  output `WORD_TP    id_qry2_val,
  input  logic       cdb_ena,
  input  `ROB_IDX_TP cdb_idx,
  input  `WORD_TP    cdb_val,
  input  logic       cdb_taken,
  input  `ADDR_TP    cdb_tgt,
  output logic       rob_wr_ena,
  output `REG_IDX_TP rob_wr_rd,
  output `WORD_TP    rob_wr_val,
  output `ROB_IDX_TP rob_wr_idx,
  output logic       rob_st_ena,
  output `ROB_IDX_TP rob_st_idx,
  output logic       rob_rb,
  output `ADDR_TP    rob_rb_pc
);

  localparam logic [ROB_BIT-1:0] ONE  = ROB_BIT'(1);
  localparam logic [ROB_BIT-1:0] LAST = ROB_BIT'(ROB_SIZE - 1);

  // Index 0 means "no producer", so the ring runs 1..LAST.
  function automatic logic [ROB_BIT-1:0] inc(input logic [ROB_BIT-1:0] x);
    return (x == LAST) ? ONE : x + ONE;
  endfunction

  logic [ROB_SIZE-1:0] busy_q, ready_q, br_q, st_q, pred_q, tkn_q;
  logic [4:0]          rd_q  [ROB_SIZE];
  logic [31:0]         val_q [ROB_SIZE];
  logic [31:0]         tgt_q [ROB_SIZE];

  logic [ROB_BIT-1:0] head_q, tail_q, cnt_q;
  logic [ROB_BIT-1:0] head_d, tail_d, cnt_d;

  logic               wr_ena_q, st_ena_q, rb_q;
  logic [4:0]         wr_rd_q;
  logic [31:0]        wr_val_q, rb_pc_q;
  logic [ROB_BIT-1:0] wr_idx_q, st_idx_q;

  logic commit, mispred, alloc_ok, cdb_ok;

  assign id_idx  = tail_q;
  assign id_full = (cnt_q == LAST);

  assign commit   = rdy && (cnt_q != '0) && ready_q[head_q];
  assign mispred  = commit && br_q[head_q] &&
                    (tkn_q[head_q] != pred_q[head_q]);
  assign alloc_ok = rdy && id_alloc && !id_full && !mispred;
  assign cdb_ok   = rdy && cdb_ena && (cdb_idx != '0) &&
                    busy_q[cdb_idx] && !mispred;

  always_comb begin
    head_d = commit ? inc(head_q) : head_q;
    tail_d = alloc_ok ? inc(tail_q) : tail_q;
    cnt_d  = cnt_q;
    if (alloc_ok && !commit) cnt_d = cnt_q + ONE;
    if (!alloc_ok && commit) cnt_d = cnt_q - ONE;
  end

  // Queries see the in-flight broadcast so dispatch need not wait a cycle.
  always_comb begin
    id_qry1_rdy = 1'b0;
    id_qry1_val = `ZERO_WORD;
    id_qry2_rdy = 1'b0;
    id_qry2_val = `ZERO_WORD;
    if (id_qry1 != '0) begin
      if (cdb_ena && cdb_idx == id_qry1) begin
        id_qry1_rdy = 1'b1;
        id_qry1_val = cdb_val;
      end else begin
        id_qry1_rdy = ready_q[id_qry1];
        id_qry1_val = val_q[id_qry1];
      end
    end
    if (id_qry2 != '0) begin
      if (cdb_ena && cdb_idx == id_qry2) begin
        id_qry2_rdy = 1'b1;
        id_qry2_val = cdb_val;
      end else begin
        id_qry2_rdy = ready_q[id_qry2];
        id_qry2_val = val_q[id_qry2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      ready_q <= '0;
      br_q    <= '0;
      st_q    <= '0;
      pred_q  <= '0;
      tkn_q   <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        rd_q[i]  <= '0;
        val_q[i] <= '0;
        tgt_q[i] <= '0;
      end
      head_q   <= ONE;
      tail_q   <= ONE;
      cnt_q    <= '0;
      wr_ena_q <= 1'b0;
      st_ena_q <= 1'b0;
      rb_q     <= 1'b0;
      wr_rd_q  <= '0;
      wr_val_q <= `ZERO_WORD;
      wr_idx_q <= `ZERO_ROB_IDX;
      st_idx_q <= `ZERO_ROB_IDX;
      rb_pc_q  <= '0;
    end else if (rdy) begin
      wr_ena_q <= 1'b0;
      st_ena_q <= 1'b0;
      rb_q     <= 1'b0;
      if (commit) begin
        if (rd_q[head_q] != '0) begin
          wr_ena_q <= 1'b1;
          wr_rd_q  <= rd_q[head_q];
          wr_val_q <= val_q[head_q];
          wr_idx_q <= head_q;
        end
        if (st_q[head_q]) begin
          st_ena_q <= 1'b1;
          st_idx_q <= head_q;
        end
        if (mispred) begin
          rb_q    <= 1'b1;
          rb_pc_q <= tgt_q[head_q];
        end
      end
      if (mispred) begin
        busy_q  <= '0;
        ready_q <= '0;
        head_q  <= ONE;
        tail_q  <= ONE;
        cnt_q   <= '0;
      end else begin
        if (alloc_ok) begin
          busy_q[tail_q]  <= 1'b1;
          ready_q[tail_q] <= 1'b0;
          rd_q[tail_q]    <= id_rd;
          br_q[tail_q]    <= id_is_br;
          st_q[tail_q]    <= id_is_st;
          pred_q[tail_q]  <= id_pred_taken;
        end
        if (cdb_ok) begin
          ready_q[cdb_idx] <= 1'b1;
          val_q[cdb_idx]   <= cdb_val;
          tkn_q[cdb_idx]   <= cdb_taken;
          tgt_q[cdb_idx]   <= cdb_tgt;
        end
        if (commit) begin
          busy_q[head_q]  <= 1'b0;
          ready_q[head_q] <= 1'b0;
        end
        head_q <= head_d;
        tail_q <= tail_d;
        cnt_q  <= cnt_d;
      end
    end else begin
      wr_ena_q <= 1'b0;
      st_ena_q <= 1'b0;
      rb_q     <= 1'b0;
    end
  end

  assign rob_wr_ena = wr_ena_q;
  assign rob_wr_rd  = wr_rd_q;
  assign rob_wr_val = wr_val_q;
  assign rob_wr_idx = wr_idx_q;
  assign rob_st_ena = st_ena_q;
  assign rob_st_idx = st_idx_q;
  assign rob_rb     = rb_q;
  assign rob_rb_pc  = rb_pc_q;

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: commit order, full/wrap, rollback,
// query bypass and stall behaviour.
module tb_rob;

  logic        clk = 1'b0;
  logic        rst, rdy, id_alloc, id_is_br, id_is_st, id_pred_taken;
  logic [4:0]  id_rd;
  logic [3:0]  id_idx, id_qry1, id_qry2, cdb_idx;
  logic        id_full, id_qry1_rdy, id_qry2_rdy;
  logic [31:0] id_qry1_val, id_qry2_val, cdb_val, cdb_tgt;
  logic        cdb_ena, cdb_taken;
  logic        rob_wr_ena, rob_st_ena, rob_rb;
  logic [4:0]  rob_wr_rd;
  logic [31:0] rob_wr_val, rob_rb_pc;
  logic [3:0]  rob_wr_idx, rob_st_idx;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rob dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .id_alloc(id_alloc), .id_rd(id_rd), .id_is_br(id_is_br),
    .id_is_st(id_is_st), .id_pred_taken(id_pred_taken),
    .id_idx(id_idx), .id_full(id_full),
    .id_qry1(id_qry1), .id_qry2(id_qry2),
    .id_qry1_rdy(id_qry1_rdy), .id_qry2_rdy(id_qry2_rdy),
    .id_qry1_val(id_qry1_val), .id_qry2_val(id_qry2_val),
    .cdb_ena(cdb_ena), .cdb_idx(cdb_idx), .cdb_val(cdb_val),
    .cdb_taken(cdb_taken), .cdb_tgt(cdb_tgt),
    .rob_wr_ena(rob_wr_ena), .rob_wr_rd(rob_wr_rd),
    .rob_wr_val(rob_wr_val), .rob_wr_idx(rob_wr_idx),
    .rob_st_ena(rob_st_ena), .rob_st_idx(rob_st_idx),
    .rob_rb(rob_rb), .rob_rb_pc(rob_rb_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_alloc = 0; id_rd = 0; id_is_br = 0; id_is_st = 0;
    id_pred_taken = 0; cdb_ena = 0; cdb_idx = 0; cdb_val = 0;
    cdb_taken = 0; cdb_tgt = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1; rdy = 1;
    step(); step();
    rst = 0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic br,
                       input logic st, input logic pr);
    id_alloc = 1; id_rd = rd; id_is_br = br;
    id_is_st = st; id_pred_taken = pr;
    step();
    idle();
  endtask

  task automatic cdb(input logic [3:0] idx, input logic [31:0] v,
                     input logic tk, input logic [31:0] tg);
    cdb_ena = 1; cdb_idx = idx; cdb_val = v;
    cdb_taken = tk; cdb_tgt = tg;
    step();
    idle();
  endtask

  initial begin
    id_qry1 = 0; id_qry2 = 0;
    // Reset state, with rdy low to show rst overrides it
    idle();
    rst = 1; rdy = 0; id_alloc = 1; id_rd = 3;
    step(); step();
    rst = 0; rdy = 1; idle();
    check("rst_idx", 32'(id_idx), 32'd1);
    check("rst_full", 32'(id_full), 32'd0);
    check("rst_wr", 32'(rob_wr_ena), 32'd0);
    check("rst_st", 32'(rob_st_ena), 32'd0);
    check("rst_rb", 32'(rob_rb), 32'd0);
    check("rst_wval", rob_wr_val, 32'h0);
    check("rst_rbpc", rob_rb_pc, 32'h0);

    // Basic alloc / broadcast / commit
    alloc(5'd5, 0, 0, 0);
    check("a1_idx", 32'(id_idx), 32'd2);
    cdb(4'd1, 32'h1234, 0, 0);
    check("a1_nocommit", 32'(rob_wr_ena), 32'd0);
    step();
    check("a1_wr", 32'(rob_wr_ena), 32'd1);
    check("a1_rd", 32'(rob_wr_rd), 32'd5);
    check("a1_val", rob_wr_val, 32'h1234);
    check("a1_widx", 32'(rob_wr_idx), 32'd1);
    step();
    check("a1_pulse", 32'(rob_wr_ena), 32'd0);

    // In-order commit with out-of-order results
    do_reset();
    alloc(5'd1, 0, 0, 0);
    alloc(5'd2, 0, 0, 0);
    alloc(5'd3, 0, 0, 0);
    cdb(4'd3, 32'h33, 0, 0);
    cdb(4'd1, 32'h11, 0, 0);
    check("ord_wait", 32'(rob_wr_ena), 32'd0);
    step();
    check("ord1_idx", 32'(rob_wr_idx), 32'd1);
    check("ord1_val", rob_wr_val, 32'h11);
    step();
    check("ord_hold3", 32'(rob_wr_ena), 32'd0);
    cdb(4'd2, 32'h22, 0, 0);
    check("ord_cdb2", 32'(rob_wr_ena), 32'd0);
    step();
    check("ord2_idx", 32'(rob_wr_idx), 32'd2);
    check("ord2_val", rob_wr_val, 32'h22);
    step();
    check("ord3_idx", 32'(rob_wr_idx), 32'd3);
    check("ord3_val", rob_wr_val, 32'h33);
    step();
    check("ord_end", 32'(rob_wr_ena), 32'd0);

    // Fill, ignored alloc when full, wrap past 0
    do_reset();
    alloc(5'd0, 0, 1, 0);
    for (int i = 0; i < 14; i++) alloc(5'd0, 0, 0, 0);
    check("full_set", 32'(id_full), 32'd1);
    check("full_idx", 32'(id_idx), 32'd1);
    alloc(5'd4, 0, 0, 0);
    check("full_ign", 32'(id_idx), 32'd1);
    cdb(4'd1, 32'h5, 0, 0);
    id_alloc = 1; id_rd = 5'd6;
    step();
    idle();
    check("full_drop", 32'(id_full), 32'd0);
    check("full_idx2", 32'(id_idx), 32'd1);
    check("st_ena", 32'(rob_st_ena), 32'd1);
    check("st_idx", 32'(rob_st_idx), 32'd1);
    check("st_nowr", 32'(rob_wr_ena), 32'd0);
    alloc(5'd0, 0, 0, 0);
    check("wrap_idx", 32'(id_idx), 32'd2);
    check("wrap_full", 32'(id_full), 32'd1);

    // Mispredicted branch rolls back
    do_reset();
    alloc(5'd0, 0, 0, 0);
    alloc(5'd9, 1, 0, 0);
    cdb(4'd1, 32'h1, 0, 0);
    cdb(4'd2, 32'h44, 1, 32'h100);
    id_alloc = 1; id_rd = 5'd7;
    step();
    idle();
    check("rb_pulse", 32'(rob_rb), 32'd1);
    check("rb_pc", rob_rb_pc, 32'h100);
    check("rb_wr", 32'(rob_wr_ena), 32'd1);
    check("rb_wrd", 32'(rob_wr_rd), 32'd9);
    check("rb_wval", rob_wr_val, 32'h44);
    check("rb_idx", 32'(id_idx), 32'd1);
    step();
    check("rb_once", 32'(rob_rb), 32'd0);
    check("rb_idle", 32'(rob_wr_ena), 32'd0);
    alloc(5'd0, 0, 0, 0);
    check("rb_next", 32'(id_idx), 32'd2);

    // Query bypass and stall
    do_reset();
    alloc(5'd7, 0, 0, 0);
    id_qry1 = 4'd1; id_qry2 = 4'd0;
    #1;
    check("q_notrdy", 32'(id_qry1_rdy), 32'd0);
    cdb_ena = 1; cdb_idx = 4'd1; cdb_val = 32'hAB;
    #1;
    check("q_byp_rdy", 32'(id_qry1_rdy), 32'd1);
    check("q_byp_val", id_qry1_val, 32'hAB);
    check("q_zero_rdy", 32'(id_qry2_rdy), 32'd0);
    check("q_zero_val", id_qry2_val, 32'h0);
    idle();
    rdy = 0; id_alloc = 1; id_rd = 5'd8;
    step();
    check("stall_idx", 32'(id_idx), 32'd2);
    check("stall_q", 32'(id_qry1_rdy), 32'd0);
    rdy = 1; idle();
    cdb(4'd1, 32'hAB, 0, 0);
    check("q_stored", id_qry1_val, 32'hAB);
    rdy = 0;
    step();
    check("stall_wr", 32'(rob_wr_ena), 32'd0);
    rdy = 1;
    step();
    check("stall_cmt", 32'(rob_wr_ena), 32'd1);
    check("stall_idx1", 32'(rob_wr_idx), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
